// File: rtl/demux_pkg.sv
// Shared types for the demux_sipo block: operating mode and fill-side FSM state.
package demux_pkg;

  typedef enum logic {
    MODE_ADDRESSED = 1'b0,
    MODE_SERIAL    = 1'b1
  } mode_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/demux_onehot_dec.sv
// SEL_W -> 2**SEL_W one-hot lane decoder, shared by the addressed write and the serial fill pointer.
module demux_onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] onehot
);

  localparam int N_OUT = 2 ** SEL_W;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
    assign onehot[gi] = (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/demux_sipo.sv
// Registered 1:N demultiplexer / serial-in parallel-out assembler with valid/ready handshake.
// Optional macro DEMUX_MSB_FIRST_EN: serial fill starts at the top lane and moves downward.
module demux_sipo
  import demux_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 1
) (
  input  logic                            inClk,
  input  logic                            inResetb,
  input  logic                            inMode,
  input  logic [DATA_W-1:0]               inData,
  input  logic [SEL_W-1:0]                inSel,
  input  logic                            inValid,
  output logic                            outReady,
  input  logic                            inFlush,
  output logic [(2**SEL_W)*DATA_W-1:0]    outData,
  output logic [SEL_W:0]                  outCount,
  output logic                            outValid,
  input  logic                            inReady
);

  localparam int N_OUT = 2 ** SEL_W;
  localparam int W     = N_OUT * DATA_W;

  state_t         state_reg, state_next;
  mode_t          mode_reg, mode_next, mode_eff;
  logic [SEL_W:0] count_reg, count_next;
  logic [W-1:0]   asm_reg, asm_next;
  logic [W-1:0]   data_reg, data_next;
  logic [SEL_W:0] ocount_reg, ocount_next;
  logic           valid_reg, valid_next;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] dec_sel;
  logic [N_OUT-1:0] lane_hot;
  logic [W-1:0]     asm_fill;
  logic [W-1:0]     addr_word;
  logic             free;
  logic             accept;
  logic             last_beat;
  logic             flush_now;

  // Mode is only sampled between words; a word in progress keeps its mode.
  assign mode_eff  = (state_reg == S_IDLE) ? mode_t'(inMode) : mode_reg;
  assign free      = !valid_reg | inReady;
  assign last_beat = (count_reg == (SEL_W+1)'(N_OUT - 1));

`ifdef DEMUX_MSB_FIRST_EN
  assign ptr = SEL_W'(N_OUT - 1) - count_reg[SEL_W-1:0];
`else
  assign ptr = count_reg[SEL_W-1:0];
`endif

  assign dec_sel = (mode_eff == MODE_SERIAL) ? ptr : inSel;

  demux_onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel    (dec_sel),
    .onehot (lane_hot)
  );

  // Partial fills proceed under backpressure; only a word-emitting beat needs a free output.
  assign outReady = (mode_eff == MODE_SERIAL) ? (free | (!last_beat & !inFlush)) : free;
  assign accept   = inValid & outReady;
  assign flush_now = (mode_eff == MODE_SERIAL) & inFlush & free & ((count_reg != '0) | accept);

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
    assign asm_fill[gi*DATA_W +: DATA_W]  = (accept & lane_hot[gi]) ? inData : asm_reg[gi*DATA_W +: DATA_W];
    assign addr_word[gi*DATA_W +: DATA_W] = lane_hot[gi] ? inData : '0;
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_eff;
    count_next  = count_reg;
    asm_next    = asm_reg;
    data_next   = data_reg;
    ocount_next = ocount_reg;
    valid_next  = valid_reg & !inReady;
    if (mode_eff == MODE_ADDRESSED) begin
      if (accept) begin
        data_next   = addr_word;
        ocount_next = (SEL_W+1)'(1);
        valid_next  = 1'b1;
      end
    end else if ((accept & last_beat) | flush_now) begin
      data_next   = asm_fill;
      ocount_next = count_reg + {{SEL_W{1'b0}}, accept};
      valid_next  = 1'b1;
      count_next  = '0;
      asm_next    = '0;
      state_next  = S_IDLE;
    end else if (accept) begin
      asm_next   = asm_fill;
      count_next = count_reg + (SEL_W+1)'(1);
      state_next = S_FILL;
    end
  end

  always_ff @(posedge inClk or negedge inResetb) begin
    if (!inResetb) begin
      state_reg  <= S_IDLE;
      mode_reg   <= MODE_ADDRESSED;
      count_reg  <= '0;
      asm_reg    <= '0;
      data_reg   <= '0;
      ocount_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      count_reg  <= count_next;
      asm_reg    <= asm_next;
      data_reg   <= data_next;
      ocount_reg <= ocount_next;
      valid_reg  <= valid_next;
    end
  end

  assign outData  = data_reg;
  assign outCount = ocount_reg;
  assign outValid = valid_reg;

endmodule

// File: tb/tb_demux_sipo.sv
// Directed bench for demux_sipo (SEL_W=3, DATA_W=1); honours DEMUX_MSB_FIRST_EN for serial expectations.
module tb_demux_sipo;

  logic       inClk = 1'b0;
  logic       inResetb;
  logic       inMode;
  logic [0:0] inData;
  logic [2:0] inSel;
  logic       inValid;
  logic       outReady;
  logic       inFlush;
  logic [7:0] outData;
  logic [3:0] outCount;
  logic       outValid;
  logic       inReady;

  int errors = 0;
  int checks = 0;

`ifdef DEMUX_MSB_FIRST_EN
  localparam logic [7:0] E_T2 = 8'hB2;
  localparam logic [7:0] E_T3 = 8'h81;
  localparam logic [7:0] E_FL = 8'hC0;
  localparam logic [7:0] E_L0 = 8'h80;
  localparam logic [7:0] E_FB = 8'hA0;
  localparam logic [7:0] E_T5 = 8'hB9;
`else
  localparam logic [7:0] E_T2 = 8'h4D;
  localparam logic [7:0] E_T3 = 8'h81;
  localparam logic [7:0] E_FL = 8'h03;
  localparam logic [7:0] E_L0 = 8'h01;
  localparam logic [7:0] E_FB = 8'h05;
  localparam logic [7:0] E_T5 = 8'h9D;
`endif

  demux_sipo #(.SEL_W(3), .DATA_W(1)) dut (
    .inClk    (inClk),
    .inResetb (inResetb),
    .inMode   (inMode),
    .inData   (inData),
    .inSel    (inSel),
    .inValid  (inValid),
    .outReady (outReady),
    .inFlush  (inFlush),
    .outData  (outData),
    .outCount (outCount),
    .outValid (outValid),
    .inReady  (inReady)
  );

  always #5 inClk = ~inClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic beat(input logic d);
    inData  = d;
    inValid = 1'b1;
    tick();
  endtask

  task automatic word(input string tag, input logic [31:0] d, input logic [31:0] c);
    check({tag, "_data"}, {24'h0, outData}, d);
    check({tag, "_count"}, {28'h0, outCount}, c);
    check({tag, "_valid"}, {31'h0, outValid}, 32'd1);
    $display("txn %s: data=%02h count=%0d valid=%0b", tag, outData, outCount, outValid);
  endtask

  task automatic beats8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) beat(b[i]);
    inValid = 1'b0;
  endtask

  initial begin
    inResetb = 1'b0; inMode = 1'b0; inData = 1'b0; inSel = 3'd0;
    inValid = 1'b0; inFlush = 1'b0; inReady = 1'b1;
    #12;
    check("rst_data", {24'h0, outData}, 32'h0);
    check("rst_count", {28'h0, outCount}, 32'h0);
    check("rst_valid", {31'h0, outValid}, 32'h0);
    inResetb = 1'b1;
    tick();

    // 1: addressed write to lane 5
    inMode = 1'b0; inSel = 3'd5; inData = 1'b1; inValid = 1'b1;
    #1 check("t1_ready", {31'h0, outReady}, 32'd1);
    tick();
    inValid = 1'b0;
    word("t1", 32'h20, 32'd1);
    tick();
    check("t1_drain", {31'h0, outValid}, 32'd0);

    // 2: serial word, bits listed lane-fill order 1,0,1,1,0,0,1,0
    inMode = 1'b1;
    beats8(8'b0100_1101);
    word("t2", {24'h0, E_T2}, 32'd8);
    tick();
    check("t2_drain", {31'h0, outValid}, 32'd0);

    // 3: backpressure; first word all ones held, second word 1,0,0,0,0,0,0,1
    inReady = 1'b0;
    beats8(8'hFF);
    word("t3_w1", 32'hFF, 32'd8);
    for (int i = 0; i < 7; i++) begin
      inData = (i == 0); inValid = 1'b1;
      #1 check($sformatf("t3_rdy%0d", i), {31'h0, outReady}, 32'd1);
      tick();
    end
    inData = 1'b1;
    #1 check("t3_stall", {31'h0, outReady}, 32'd0);
    tick();
    word("t3_hold", 32'hFF, 32'd8);
    inReady = 1'b1;
    #1 check("t3_free", {31'h0, outReady}, 32'd1);
    tick();
    inValid = 1'b0;
    word("t3_w2", {24'h0, E_T3}, 32'd8);
    tick();

    // 4: flush of partial word 1,1,0; then flush together with a beat; then fresh word
    beat(1'b1); beat(1'b1); beat(1'b0);
    inValid = 1'b0; inFlush = 1'b1;
    tick();
    word("t4_flush", {24'h0, E_FL}, 32'd3);
    tick();
    check("t4_noop", {31'h0, outValid}, 32'd0);
    inFlush = 1'b0;
    beat(1'b1); beat(1'b0);
    inFlush = 1'b1; beat(1'b1);
    inFlush = 1'b0; inValid = 1'b0;
    word("t4_fbeat", {24'h0, E_FB}, 32'd3);
    beats8(8'h01);
    word("t4_next", {24'h0, E_L0}, 32'd8);
    tick();

    // 5: mode drops to addressed mid-word; word still completes serially
    inMode = 1'b1;
    beat(1'b1); beat(1'b0); beat(1'b1);
    inMode = 1'b0; inSel = 3'd2;
    beat(1'b1); beat(1'b1); beat(1'b0); beat(1'b0); beat(1'b1);
    inValid = 1'b0;
    word("t5", {24'h0, E_T5}, 32'd8);
    beat(1'b1);
    inValid = 1'b0;
    word("t5_addr", 32'h04, 32'd1);
    tick();

    // 6: async reset mid-word with a pending output word
    inReady = 1'b0; inMode = 1'b0; inSel = 3'd7;
    beat(1'b1);
    inMode = 1'b1;
    beat(1'b1); beat(1'b1); beat(1'b1); beat(1'b1);
    inValid = 1'b0;
    word("t6_pend", 32'h80, 32'd1);
    #2 inResetb = 1'b0;
    #1;
    check("t6_data", {24'h0, outData}, 32'h0);
    check("t6_count", {28'h0, outCount}, 32'h0);
    check("t6_valid", {31'h0, outValid}, 32'h0);
    #1 inResetb = 1'b1;
    inReady = 1'b1;
    tick();
    beats8(8'h01);
    word("t6_next", {24'h0, E_L0}, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
